// File: rtl/multiply_arbiter.sv
//-----------------------------------------------------------------------------
// multiply_arbiter
//
// Purpose:
//   Round-robin arbiter and sequencer that lets two requesters share one
//   8x8 unsigned shift-add multiplier. The winning requester's operands are
//   captured at grant time and sent to the multiplier over its 8-bit bus on
//   two consecutive cycles (multiplicand, then multiplier). The arbiter then
//   waits for the multiplier to finish, or gives up after TIMEOUT cycles.
//   It returns the 16-bit product, or 0 with error set, together with a
//   one-cycle acknowledge to the owner.
//
// Parameters:
//   TIMEOUT      maximum cycles spent in WAIT before aborting (12..255)
//
// Ports:
//   clock        system clock, all state changes on the rising edge
//   reset_n      asynchronous, active-low reset
//   req0/req1    requests; held high with stable operands until acknowledged
//   a0/b0        requester 0 multiplicand / multiplier
//   a1/b1        requester 1 multiplicand / multiplier
//   ack0/ack1    one-cycle result-valid pulse for requester 0 / 1
//   result       product (0 on timeout), valid with ack, held until next ack
//   error        set with ack when the operation timed out
//   busy         high in every state except IDLE
//   mul_start    high for exactly the cycle the multiplicand is on the bus
//   bus          multiplier operand bus
//   mul_done     multiplier completion (level or pulse), looked at in WAIT only
//   mul_product  multiplier product, captured when mul_done is seen
//
// All outputs come straight from flops.
//-----------------------------------------------------------------------------
module multiply_arbiter #(
    parameter int TIMEOUT = 32
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req0,
    input  logic [7:0]  a0,
    input  logic [7:0]  b0,
    input  logic        req1,
    input  logic [7:0]  a1,
    input  logic [7:0]  b1,
    output logic        ack0,
    output logic        ack1,
    output logic [15:0] result,
    output logic        error,
    output logic        busy,
    output logic        mul_start,
    output logic [7:0]  bus,
    input  logic        mul_done,
    input  logic [15:0] mul_product
);

    // The counter holds 0 in the first WAIT cycle, so reaching TIMEOUT-1
    // means TIMEOUT WAIT cycles have elapsed.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t      state_q,      state_d;
    logic        last_grant_q, last_grant_d;
    logic        owner_q,      owner_d;
    logic [7:0]  a_q,          a_d;
    logic [7:0]  b_q,          b_d;
    logic [7:0]  cnt_q,        cnt_d;
    logic        ack0_q,       ack0_d;
    logic        ack1_q,       ack1_d;
    logic [15:0] result_q,     result_d;
    logic        error_q,      error_d;
    logic        busy_q,       busy_d;
    logic        mul_start_q,  mul_start_d;
    logic [7:0]  bus_q,        bus_d;
    logic        grant_id;

    // Next-state and next-output logic for the whole sequencer. Outputs are
    // computed one cycle ahead from the state being entered, so each
    // registered output lines up with the state it belongs to.
    // For example, mul_start and the multiplicand are computed at grant and
    // appear during LOAD_A.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        a_d          = a_q;
        b_d          = b_q;
        cnt_d        = cnt_q;
        result_d     = result_q;
        error_d      = error_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        mul_start_d  = 1'b0;
        bus_d        = 8'd0;
        grant_id     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    // On contention, the requester that did not win last
                    // time gets the grant. This gives strict alternation.
                    if (req0 && req1) begin
                        grant_id = ~last_grant_q;
                    end else begin
                        grant_id = req1;
                    end
                    owner_d      = grant_id;
                    last_grant_d = grant_id;
                    a_d          = grant_id ? a1 : a0;
                    b_d          = grant_id ? b1 : b0;
                    mul_start_d  = 1'b1;
                    bus_d        = grant_id ? a1 : a0;
                    state_d      = ST_LOAD_A;
                end
            end

            ST_LOAD_A: begin
                bus_d   = b_q;
                state_d = ST_LOAD_B;
            end

            ST_LOAD_B: begin
                cnt_d   = 8'd0;
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                // A completion wins over a timeout in the same cycle.
                if (mul_done) begin
                    result_d = mul_product;
                    error_d  = 1'b0;
                    ack0_d   = ~owner_q;
                    ack1_d   = owner_q;
                    state_d  = ST_RESP;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    result_d = 16'd0;
                    error_d  = 1'b1;
                    ack0_d   = ~owner_q;
                    ack1_d   = owner_q;
                    state_d  = ST_RESP;
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // Single state register for the FSM and all registered outputs.
    // last_grant resets to 1 so that requester 0 wins the first contention.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            a_q          <= 8'd0;
            b_q          <= 8'd0;
            cnt_q        <= 8'd0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            result_q     <= 16'd0;
            error_q      <= 1'b0;
            busy_q       <= 1'b0;
            mul_start_q  <= 1'b0;
            bus_q        <= 8'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            a_q          <= a_d;
            b_q          <= b_d;
            cnt_q        <= cnt_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            result_q     <= result_d;
            error_q      <= error_d;
            busy_q       <= busy_d;
            mul_start_q  <= mul_start_d;
            bus_q        <= bus_d;
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign result    = result_q;
    assign error     = error_q;
    assign busy      = busy_q;
    assign mul_start = mul_start_q;
    assign bus       = bus_q;

endmodule

// File: tb/tb_multiply_arbiter.sv
//-----------------------------------------------------------------------------
// tb_multiply_arbiter
//
// Self-checking bench for multiply_arbiter. The bench acts as the
// multiplier: it captures the two bus values and answers with their
// product after a chosen number of WAIT cycles. Expected products are
// hand-computed constants.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_multiply_arbiter;

    localparam int TMO = 16;

    logic        clock;
    logic        reset_n;
    logic        req0;
    logic [7:0]  a0;
    logic [7:0]  b0;
    logic        req1;
    logic [7:0]  a1;
    logic [7:0]  b1;
    logic        ack0;
    logic        ack1;
    logic [15:0] result;
    logic        error;
    logic        busy;
    logic        mul_start;
    logic [7:0]  bus;
    logic        mul_done;
    logic [15:0] mul_product;

    int num_checks;
    int num_miscompares;

    typedef struct {
        logic        who;
        logic [7:0]  a;
        logic [7:0]  b;
        int          k;
        logic [15:0] exp_result;
    } vec_t;

    vec_t vecs [7];

    multiply_arbiter #(.TIMEOUT(TMO)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req0        (req0),
        .a0          (a0),
        .b0          (b0),
        .req1        (req1),
        .a1          (a1),
        .b1          (b1),
        .ack0        (ack0),
        .ack1        (ack1),
        .result      (result),
        .error       (error),
        .busy        (busy),
        .mul_start   (mul_start),
        .bus         (bus),
        .mul_done    (mul_done),
        .mul_product (mul_product)
    );

    // Free-running 100 MHz clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hard time limit so the run always ends even if the sequencing is lost.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compare one observed value against its expected value and keep score.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Run one operation through the arbiter. The caller has set up the
    // requests, and the DUT is in IDLE just before the grant edge. On
    // return the DUT is in the IDLE cycle after RESP. The task does four
    // things:
    //   - It pulses mul_done as a stray during LOAD_A/LOAD_B.
    //   - It scrambles every operand input during WAIT.
    //   - It raises mul_done at WAIT cycle done_at (0 = never).
    //   - It expects the ack after wait_cycles WAIT cycles.
    task automatic runOp(input logic        exp_owner,
                         input logic [7:0]  exp_a,
                         input logic [7:0]  exp_b,
                         input int          done_at,
                         input int          wait_cycles,
                         input logic [15:0] exp_result,
                         input logic        exp_err);
        logic [7:0] a_cap, b_cap;
        logic [7:0] sa0, sb0, sa1, sb1;

        @(posedge clock); #1;
        checkOutput("loada_mul_start", mul_start, 1);
        checkOutput("loada_bus", bus, exp_a);
        checkOutput("loada_busy", busy, 1);
        a_cap       = bus;
        mul_done    = 1'b1;
        mul_product = 16'hDEAD;

        @(posedge clock); #1;
        checkOutput("loadb_mul_start", mul_start, 0);
        checkOutput("loadb_bus", bus, exp_b);
        b_cap = bus;

        @(posedge clock); #1;
        checkOutput("wait_bus", bus, 0);
        checkOutput("wait_busy", busy, 1);
        sa0 = a0; sb0 = b0; sa1 = a1; sb1 = b1;
        a0 = ~a0; b0 = ~b0; a1 = ~a1; b1 = ~b1;

        for (int j = 1; j <= wait_cycles; j++) begin
            if (j == done_at) begin
                mul_done    = 1'b1;
                mul_product = 16'(a_cap) * 16'(b_cap);
            end else begin
                mul_done    = 1'b0;
                mul_product = 16'hBEEF;
            end
            @(posedge clock); #1;
            if (j < wait_cycles) begin
                checkOutput("wait_no_ack", {30'd0, ack0, ack1}, 0);
            end
        end
        mul_done    = 1'b0;
        mul_product = 16'h0000;
        a0 = sa0; b0 = sb0; a1 = sa1; b1 = sb1;

        checkOutput("resp_ack0", ack0, !exp_owner);
        checkOutput("resp_ack1", ack1, exp_owner);
        checkOutput("resp_result", result, exp_result);
        checkOutput("resp_error", error, exp_err);

        @(posedge clock); #1;
        checkOutput("idle_acks", {30'd0, ack0, ack1}, 0);
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_result_hold", result, exp_result);
        checkOutput("idle_error_hold", error, exp_err);
    endtask

    // Apply one table vector: raise the request, run it, drop the request.
    task automatic applyStimulus(input vec_t v);
        if (v.who) begin
            req1 = 1'b1; a1 = v.a; b1 = v.b;
        end else begin
            req0 = 1'b1; a0 = v.a; b0 = v.b;
        end
        runOp(v.who, v.a, v.b, v.k, v.k, v.exp_result, 1'b0);
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    // Main test sequence.
    initial begin
        num_checks      = 0;
        num_miscompares = 0;

        vecs[0] = '{who: 1'b0, a: 8'd13,  b: 8'd11,  k: 3, exp_result: 16'd143};
        vecs[1] = '{who: 1'b1, a: 8'd255, b: 8'd255, k: 1, exp_result: 16'hFE01};
        vecs[2] = '{who: 1'b0, a: 8'd0,   b: 8'd200, k: 2, exp_result: 16'd0};
        vecs[3] = '{who: 1'b1, a: 8'd16,  b: 8'd16,  k: 4, exp_result: 16'd256};
        vecs[4] = '{who: 1'b0, a: 8'd7,   b: 8'd9,   k: 1, exp_result: 16'd63};
        vecs[5] = '{who: 1'b1, a: 8'd255, b: 8'd1,   k: 5, exp_result: 16'd255};
        vecs[6] = '{who: 1'b0, a: 8'd200, b: 8'd200, k: 2, exp_result: 16'd40000};

        reset_n     = 1'b0;
        req0        = 1'b0; a0 = 8'd0; b0 = 8'd0;
        req1        = 1'b0; a1 = 8'd0; b1 = 8'd0;
        mul_done    = 1'b0;
        mul_product = 16'd0;

        // Reset state, sampled while reset is still asserted.
        repeat (2) @(posedge clock);
        #1;
        checkOutput("rst_ack0", ack0, 0);
        checkOutput("rst_ack1", ack1, 0);
        checkOutput("rst_result", result, 0);
        checkOutput("rst_error", error, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_mul_start", mul_start, 0);
        checkOutput("rst_bus", bus, 0);
        reset_n = 1'b1;

        // Contention straight after reset: requester 0 first, then 1.
        $display("[TB] contention after reset");
        req0 = 1'b1; a0 = 8'd255; b0 = 8'd255;
        req1 = 1'b1; a1 = 8'd2;   b1 = 8'd3;
        runOp(1'b0, 8'd255, 8'd255, 2, 2, 16'hFE01, 1'b0);
        runOp(1'b1, 8'd2,   8'd3,   1, 1, 16'd6,    1'b0);
        req0 = 1'b0; req1 = 1'b0;

        // Fairness: both held for six operations, strict alternation.
        $display("[TB] fairness");
        req0 = 1'b1; a0 = 8'd3; b0 = 8'd4;
        req1 = 1'b1; a1 = 8'd5; b1 = 8'd6;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 1) begin
                runOp(1'b1, 8'd5, 8'd6, 1, 1, 16'd30, 1'b0);
            end else begin
                runOp(1'b0, 8'd3, 8'd4, 1, 1, 16'd12, 1'b0);
            end
        end
        req0 = 1'b0; req1 = 1'b0;

        // Table-driven single-requester operations.
        $display("[TB] directed vectors");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i]);
        end

        // Timeout, then a normal op that must clear the error.
        $display("[TB] timeout");
        req0 = 1'b1; a0 = 8'd9; b0 = 8'd9;
        runOp(1'b0, 8'd9, 8'd9, 0, TMO, 16'd0, 1'b1);
        req0 = 1'b0;
        req1 = 1'b1; a1 = 8'd10; b1 = 8'd10;
        runOp(1'b1, 8'd10, 8'd10, 2, 2, 16'd100, 1'b0);
        req1 = 1'b0;

        // Reset pulse in the middle of WAIT, with requester 1 also pending.
        $display("[TB] reset during wait");
        req0 = 1'b1; a0 = 8'd4; b0 = 8'd5;
        @(posedge clock); #1;
        checkOutput("mid_loada_mul_start", mul_start, 1);
        @(posedge clock); #1;
        @(posedge clock); #1;
        req1 = 1'b1; a1 = 8'd6; b1 = 8'd7;
        @(posedge clock); #1;
        checkOutput("mid_wait_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_ack0", ack0, 0);
        checkOutput("mid_rst_ack1", ack1, 0);
        checkOutput("mid_rst_result", result, 0);
        checkOutput("mid_rst_error", error, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_mul_start", mul_start, 0);
        checkOutput("mid_rst_bus", bus, 0);
        #2;
        reset_n = 1'b1;
        runOp(1'b0, 8'd4, 8'd5, 1, 1, 16'd20, 1'b0);
        req0 = 1'b0;
        runOp(1'b1, 8'd6, 8'd7, 3, 3, 16'd42, 1'b0);
        req1 = 1'b0;

        repeat (2) @(posedge clock);
        #1;
        checkOutput("final_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", num_checks, num_miscompares);
        $finish;
    end

endmodule

// File: doc/multiply_arbiter.md
Name: multiply_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 8x8 unsigned shift-add multiplier between two requesters.
- Captures a requester's operands and presents them to the multiplier over its 8-bit input bus in two consecutive cycles: multiplicand first, then multiplier.
- Waits for the multiplier to finish, then returns the 16-bit product to the granted requester with a one-cycle acknowledge.
- Sits between client logic (e.g. the datapath FSM) and the multiplier; it is the only block that drives the multiplier's bus.

Parameters:
- TIMEOUT, 32, max cycles spent in WAIT before the operation is aborted with an error (legal range 12..255).

Ports:
- clock  input  1  system clock, all state changes on rising edge
- reset_n  input  1  asynchronous, active-low reset
- req0  input  1  requester 0 request; held high with stable operands until ack0
- a0  input  8  requester 0 multiplicand
- b0  input  8  requester 0 multiplier
- req1  input  1  requester 1 request; same rules as req0
- a1  input  8  requester 1 multiplicand
- b1  input  8  requester 1 multiplier
- ack0  output  1  one-cycle pulse: result valid for requester 0
- ack1  output  1  one-cycle pulse: result valid for requester 1
- result  output  16  product (or 0 on error), valid while ack0/ack1 is high
- error  output  1  high with ack when the operation timed out
- busy  output  1  high in every state except IDLE
- mul_start  output  1  high for exactly the LOAD_A cycle
- bus  output  8  multiplier input bus
- mul_done  input  1  multiplier completion, level or pulse, sampled in WAIT only
- mul_product  input  16  multiplier product, sampled when mul_done is seen

Behaviour:
- Reset (async, reset_n=0): state=IDLE, last_grant=1 (so requester 0 wins first), ack0=ack1=0, result=0, error=0, busy=0, mul_start=0, bus=0, timeout counter=0. Operand and owner registers are cleared.
- All outputs are registered.
- IDLE:
  - No request: stay in IDLE; bus=0.
  - Only one request: grant it.
  - Both requests: grant the one not equal to last_grant.
  - On grant: latch a/b of the winner, latch owner id, set last_grant=owner, go to LOAD_A.
- LOAD_A: mul_start=1, bus=latched a. Next state is LOAD_B.
- LOAD_B: mul_start=0, bus=latched b. Clear the timeout counter. Next state is WAIT.
- WAIT:
  - bus=0; the counter increments each cycle.
  - If mul_done=1: latch mul_product into result, error=0, go to RESP.
  - Else if the counter reaches TIMEOUT-1: result=0, error=1, go to RESP.
  - mul_done takes priority when both occur in the same cycle.
- RESP:
  - Assert ack of the owner for exactly one cycle; result/error hold their values.
  - Go to IDLE. result and error keep their values until the next RESP.
- Latency for a single requester with an idle arbiter:
  - req seen at edge 0 → LOAD_A at cycle 1 → LOAD_B at cycle 2 → WAIT from cycle 3.
  - If mul_done arrives k cycles into WAIT (k≥1), ack is high at cycle 3+k.
- Re-arbitration: a requester that keeps req high after ack may be granted again. When both requesters are active, strict alternation is required.
- Dropped request: a requester that drops req after grant but before ack is ignored; the operation completes and ack still pulses.
- Operand capture: operands are captured only at grant. Later changes to a0/b0/a1/b1 do not affect the operation in flight.
- Stray mul_done: mul_done outside WAIT is ignored.
- Reset mid-operation: returns to IDLE immediately. No ack is issued and mul_start/bus drop to 0 asynchronously.
- Arithmetic: unsigned; result is 16 bits and passed through unchanged from mul_product.

Test Plan:
- Single op: req0, a0=8'd13, b0=8'd11; model returns 143 three cycles into WAIT → mul_start high one cycle with bus=13, then bus=11, then ack0 one cycle with result=16'd143, error=0.
- Contention after reset: req0 and req1 rise together with (255,255) and (2,3) → requester 0 served first (result 16'hFE01), then requester 1 (result 6). ack0 and ack1 are never high together; busy stays high except a single IDLE cycle between operations.
- Fairness: req0 and req1 held high for 6 operations → ack order is 0,1,0,1,0,1.
- Timeout: mul_done held 0 → ack with error=1 and result=0 exactly TIMEOUT cycles after entering WAIT. A following normal op clears error.
- Reset mid-WAIT: pulse reset_n low during WAIT → all outputs 0 immediately, state IDLE, no ack. A pending req is granted to requester 0 after release.
- Operand stability/edges: change a0 during WAIT, and run a=0,b=200 → result comes from the captured values; the zero product reports 16'd0 with error=0.
